grf_mp: RTL and testbench
=========================

# grf_mp

Parametrised multi-read-port general register file for the pipelined CPU datapath. Replaces the single-cycle GRF. Adds:
- configurable width, depth and read-port count;
- same-cycle write-to-read forwarding;
- a per-register pending-write scoreboard for hazard detection;
- a multi-cycle sequential clear engine with a request/busy/done handshake.

It sits between decode (reads, issue) and writeback (writes).

## Interface
- DW, 32, data width in bits
- AW, 5, address width; depth = 2**AW entries
- NR, 2, number of read ports (1..4)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; zeroes all entries, busy bits and clear-engine state
- we  in  1  write enable (writeback stage)
- wa  in  AW  write address
- wd  in  DW  write data
- wpc  in  32  PC of the writing instruction; used only for trace
- ra  in  NR*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rd  out  NR*DW  packed read data; port k uses bits [k*DW +: DW]
- rbusy  out  NR  per-port pending-write flag for ra[k]
- iss_vld  in  1  issue of an instruction that will write iss_a
- iss_a  in  AW  destination register being issued
- clr_req  in  1  request a full-file clear
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse when the clear completes

## Operation
- Entry 0 is hard zero:
  - writes to address 0 are discarded;
  - rd for ra=0 is 0;
  - busy[0] is never set.
- Write: when we=1 and the file is not in CLEAR, mem[wa] <= wd at posedge, for wa≠0.
- Forwarding: for each port k, rd[k] = wd if (we && wa==ra[k] && wa≠0 && !clr_busy); otherwise rd[k] = mem[ra[k]].
- Scoreboard, updated at posedge:
  - iss_vld sets busy[iss_a] (iss_a≠0);
  - an accepted write clears busy[wa];
  - if iss_vld and we target the same address in the same cycle, the set wins (a new producer is pending).
- rbusy[k] = busy[ra[k]] && !(we && wa==ra[k] && !clr_busy). A forwarded value is never reported busy.
- Clear FSM states are IDLE, CLEAR and DONE:
  - IDLE→CLEAR when clr_req=1. On that edge all busy bits are cleared and idx <= 0.
  - CLEAR: mem[idx] <= 0 each cycle and idx increments. When idx == 2**AW-1, go to DONE.
  - DONE: clr_done=1 for one cycle, then IDLE.
  - clr_req in CLEAR or DONE is ignored; there is no queueing.
- During CLEAR and DONE:
  - we and iss_vld are ignored; the writes are dropped and the caller must stall;
  - reads return the current mem contents, so entries not yet cleared show their old values.

## Timing
- Reset values: rd = 0 for all addresses, rbusy = 0, clr_busy = 0, clr_done = 0, state = IDLE, idx = 0.
- Read path is combinational from ra/we/wa/wd, with 0-cycle latency.
- Write, scoreboard and FSM update at posedge clk.
- Clear latency: clr_busy rises 1 cycle after clr_req is sampled and stays high for 2**AW + 1 cycles (CLEAR plus DONE). clr_done is high in the last of those cycles. clr_busy = (state≠IDLE).
- Reset asserted mid-clear forces IDLE immediately with everything zeroed. clr_done does not pulse.
- idx is AW bits wide; the terminal compare is done before the increment, so there is no wrap.

## Configuration
- GRF_TRACE_EN defined: on every accepted write (we=1, not in CLEAR), including wa=0, print "@%h: $%d <= %h" with wpc, wa, wd at the posedge.
- Undefined: no display statements are compiled; behaviour is otherwise identical.

## Structure
- Package grf_pkg holds:
  - the clear-state enum (IDLE, CLEAR, DONE);
  - default DW/AW/NR localparams;
  - the trace format string.
- Sub-module grf_clear_fsm contains the state register, idx counter, clr_busy/clr_done and the per-cycle clear write strobe. The top module owns the array, the forwarding muxes and the scoreboard.

## Test plan
- Reset, then read ra={5'd3, 5'd0} -> rd={0, 0} and rbusy=0.
- Write we=1, wa=5, wd=32'hDEADBEEF with ra[0]=5 in the same cycle -> rd[0]=DEADBEEF combinationally. After the edge, with we=0, rd[0] still equals DEADBEEF.
- Write wa=0, wd=32'h1234 -> rd for ra=0 stays 0. With GRF_TRACE_EN, one trace line is printed.
- Scoreboard:
  - iss_vld with iss_a=7 -> next cycle rbusy for ra=7 is 1;
  - we=1, wa=7 -> rbusy for ra=7 is 0 in that same cycle and stays 0 after the edge;
  - iss_a=7 together with we, wa=7 -> busy[7] remains 1.
- Preload r1..r31 with nonzero values, then pulse clr_req:
  - clr_busy is high for 33 cycles (AW=5);
  - clr_done is high only in the last of them;
  - a we to r4 during the clear is dropped;
  - all reads are 0 afterwards.
- Assert reset in the middle of a clear, at idx=10 -> clr_busy=0 immediately, every entry reads 0, and no clr_done pulse occurs.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared types and defaults for the multi-port general register file.
// Optional feature macro: GRF_TRACE_EN (write trace printing).
package grf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int NR_DEF = 2;

    localparam string TRACE_FMT = "@%h: $%d <= %h";

endpackage

// File: rtl/grf_clear_fsm.sv
// Sequential clear engine: walks every entry once, then pulses done.
// Owns the state register, entry index and the clear write strobe.
module grf_clear_fsm
    import grf_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_start,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx,
    output logic          clr_busy,
    output logic          clr_done
);

    clr_state_t state;

    assign clr_start = (state == IDLE) && clr_req;
    assign clr_we    = (state == CLEAR);

    // IDLE -> CLEAR on request, sweep all entries, one DONE cycle, back to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_idx  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (&clr_idx) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/grf_mp.sv
// Multi-read-port register file with write forwarding, pending-write
// scoreboard and sequential clear. Define GRF_TRACE_EN for write trace.
module grf_mp
    import grf_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int NR = NR_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [DW-1:0]    wd,
    input  logic [31:0]      wpc,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rbusy,
    input  logic             iss_vld,
    input  logic [AW-1:0]    iss_a,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             clr_start;
    logic             clr_we;
    logic [AW-1:0]    clr_idx;
    logic             wr_ok;

    // Writes and issues are dropped while the clear engine runs
    assign wr_ok = we && !clr_busy;

    grf_clear_fsm #(
        .AW(AW)
    ) u_clr (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_start(clr_start),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    // Storage: clear sweep has priority; entry 0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // Scoreboard: a new issue to the same register outranks its write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else if (clr_start) begin
            busy <= '0;
        end else if (!clr_busy) begin
            if (we && wa != '0) begin
                busy[wa] <= 1'b0;
            end
            if (iss_vld && iss_a != '0) begin
                busy[iss_a] <= 1'b1;
            end
        end
    end

    // Read ports: bypass same-cycle write data, mask busy on a forward
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int k = 0; k < NR; k++) begin
            if (wr_ok && wa != '0 && wa == ra[k*AW +: AW]) begin
                rd[k*DW +: DW] = wd;
            end else begin
                rd[k*DW +: DW] = mem[ra[k*AW +: AW]];
            end
            rbusy[k] = busy[ra[k*AW +: AW]]
                       && !(wr_ok && wa == ra[k*AW +: AW]);
        end
    end

`ifdef GRF_TRACE_EN
    // Trace every accepted write, including the discarded ones to $0
    always @(posedge clk) begin
        if (!reset && wr_ok) begin
            $display("%s", $sformatf(TRACE_FMT, wpc, wa, wd));
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^wpc;
`endif

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: vector table, clear/reset sequences,
// and randomized traffic against a behavioural register-file model.
module tb_grf_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int N  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [31:0]      wpc;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic             iss_vld;
    logic [AW-1:0]    iss_a;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;

    grf_mp #(.DW(DW), .AW(AW), .NR(NR)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .wpc     (wpc),
        .ra      (ra),
        .rd      (rd),
        .rbusy   (rbusy),
        .iss_vld (iss_vld),
        .iss_a   (iss_a),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        b0;
        logic        b1;
    } vec_t;

    vec_t vt[14];

    // behavioural model state
    logic [31:0] mm[N];
    bit          mb[N];
    int          ph;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [4:0] a,
                                input logic [31:0] d, input logic i,
                                input logic [4:0] ia, input logic [4:0] r0,
                                input logic [4:0] r1, input logic [31:0] e0,
                                input logic [31:0] e1, input logic b0,
                                input logic b1);
        vec_t v;
        v.we = w; v.wa = a; v.wd = d; v.iss = i; v.ia = ia;
        v.ra0 = r0; v.ra1 = r1; v.e0 = e0; v.e1 = e1;
        v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic idle_in();
        we = 0; wa = 0; wd = 0; wpc = 0;
        iss_vld = 0; iss_a = 0; clr_req = 0; ra = 0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;
        #1;
    endtask

    task automatic preload(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            we = 1; wa = 5'(r); wd = 32'h1000_0000 | r;
            @(posedge clk);
            #1;
        end
        we = 0;
    endtask

    initial begin
        int busy_n;
        int done_n;
        int done_at;
        int seen;
        logic [4:0] a0;
        logic [4:0] a1;
        logic [31:0] x0;
        logic [31:0] x1;
        bit m_busy;

        vt[0]  = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 5, 3, 32'hDEADBEEF, 0, 0, 0);
        vt[3]  = mk(1, 0, 32'h1234, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0);
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0);
        vt[5]  = mk(0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 7, 5, 0, 32'hDEADBEEF, 1, 0);
        vt[7]  = mk(1, 7, 32'h77, 0, 0, 7, 0, 32'h77, 0, 0, 0);
        vt[8]  = mk(0, 0, 0, 0, 0, 7, 0, 32'h77, 0, 0, 0);
        vt[9]  = mk(1, 7, 32'h88, 1, 7, 7, 0, 32'h88, 0, 0, 0);
        vt[10] = mk(0, 0, 0, 0, 0, 7, 0, 32'h88, 0, 1, 0);
        vt[11] = mk(1, 9, 32'hAA, 0, 0, 9, 7, 32'hAA, 32'h88, 0, 1);
        vt[12] = mk(1, 7, 32'h99, 0, 0, 7, 9, 32'h99, 32'hAA, 0, 0);
        vt[13] = mk(0, 0, 0, 0, 0, 7, 9, 32'h99, 32'hAA, 0, 0);

        // reset state
        do_reset();
        chk("rst_clr_busy", {31'b0, clr_busy}, 0);
        chk("rst_clr_done", {31'b0, clr_done}, 0);

        // table vectors, one per cycle
        for (int i = 0; i < 14; i++) begin
            we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
            wpc = 32'(i * 4);
            iss_vld = vt[i].iss; iss_a = vt[i].ia;
            ra = {vt[i].ra1, vt[i].ra0};
            #1;
            chk($sformatf("vec%0d_rd0", i), rd[31:0], vt[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd[63:32], vt[i].e1);
            chk($sformatf("vec%0d_rb0", i), {31'b0, rbusy[0]},
                {31'b0, vt[i].b0});
            chk($sformatf("vec%0d_rb1", i), {31'b0, rbusy[1]},
                {31'b0, vt[i].b1});
            @(posedge clk);
            #1;
        end
        idle_in();

        // full clear with a dropped write and issue
        do_reset();
        preload(1, 31);
        clr_req = 1;
        @(posedge clk);
        #1 clr_req = 0;
        busy_n = 0; done_n = 0; done_at = 0;
        for (int c = 0; c < 100; c++) begin
            if (!clr_busy) break;
            busy_n++;
            if (clr_done) begin
                done_n++;
                done_at = busy_n;
            end
            if (busy_n == 2) begin
                ra = {5'd20, 5'd0};
                #1 chk("clr_old_r20", rd[63:32], 32'h1000_0014);
            end
            if (busy_n == 20) begin
                we = 1; wa = 4; wd = 32'h555;
                iss_vld = 1; iss_a = 4;
                ra = {5'd0, 5'd4};
                #1 chk("clr_nofwd_r4", rd[31:0], 0);
            end
            @(posedge clk);
            #1;
            we = 0; iss_vld = 0;
        end
        chk("clr_busy_len", busy_n, 33);
        chk("clr_done_cnt", done_n, 1);
        chk("clr_done_pos", done_at, 33);
        for (int r = 0; r < N; r++) begin
            ra = {5'(r), 5'(r)};
            #1;
            chk($sformatf("clr_zero_r%0d", r), rd[31:0], 0);
        end
        ra = {5'd0, 5'd4};
        #1 chk("clr_iss_drop", {31'b0, rbusy[0]}, 0);
        idle_in();

        // reset in the middle of a clear
        do_reset();
        preload(1, 31);
        clr_req = 1;
        @(posedge clk);
        #1 clr_req = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy_pre", {31'b0, clr_busy}, 1);
        reset = 1;
        #1;
        chk("mid_busy_rst", {31'b0, clr_busy}, 0);
        chk("mid_done_rst", {31'b0, clr_done}, 0);
        for (int r = 1; r < N; r += 3) begin
            ra = {5'(r), 5'(r)};
            #1;
            chk($sformatf("mid_zero_r%0d", r), rd[31:0], 0);
        end
        @(posedge clk);
        #1 reset = 0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (clr_done || clr_busy) seen++;
        end
        chk("mid_no_done", seen, 0);

        // randomized traffic against the model
        do_reset();
        for (int r = 0; r < N; r++) begin
            mm[r] = 0;
            mb[r] = 0;
        end
        ph = -1;
        for (int c = 0; c < 1500; c++) begin
            we = 1'($urandom % 2);
            wa = 5'($urandom % 32);
            wd = $urandom;
            wpc = 32'(c * 4);
            iss_vld = ($urandom % 4) == 0;
            iss_a = 5'($urandom % 32);
            clr_req = ($urandom % 60) == 0;
            a0 = ($urandom % 3 == 0) ? wa : 5'($urandom % 32);
            a1 = ($urandom % 3 == 0) ? iss_a : 5'($urandom % 32);
            ra = {a1, a0};
            #1;
            m_busy = (ph >= 0);
            x0 = (we && !m_busy && wa == a0 && wa != 0) ? wd :
                 (a0 == 0 ? 32'h0 : mm[a0]);
            x1 = (we && !m_busy && wa == a1 && wa != 0) ? wd :
                 (a1 == 0 ? 32'h0 : mm[a1]);
            chk("rnd_rd0", rd[31:0], x0);
            chk("rnd_rd1", rd[63:32], x1);
            chk("rnd_rb0", {31'b0, rbusy[0]},
                {31'b0, mb[a0] && !(we && !m_busy && wa == a0)});
            chk("rnd_rb1", {31'b0, rbusy[1]},
                {31'b0, mb[a1] && !(we && !m_busy && wa == a1)});
            chk("rnd_cbusy", {31'b0, clr_busy}, {31'b0, m_busy});
            chk("rnd_cdone", {31'b0, clr_done}, {31'b0, ph == N});
            @(posedge clk);
            if (ph < 0) begin
                if (we && wa != 0) begin
                    mm[wa] = wd;
                    mb[wa] = 0;
                end
                if (clr_req) begin
                    for (int r = 0; r < N; r++) mb[r] = 0;
                    ph = 0;
                end else if (iss_vld && iss_a != 0) begin
                    mb[iss_a] = 1;
                end
            end else if (ph < N) begin
                mm[ph] = 0;
                ph++;
            end else begin
                ph = -1;
            end
            #1;
        end
        idle_in();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
